// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S / left-justified transmitter.
// Samples are MSB-aligned in MAX_W-bit fields so any SAMPLE_W fits.
package i2s_pkg;

  localparam int MAX_W = 32;

  // Stereo pair; a SAMPLE_W sample occupies the top SAMPLE_W bits.
  typedef struct packed {
    logic [MAX_W-1:0] left;
    logic [MAX_W-1:0] right;
  } stereo_t;

  function automatic int frame_bits(int slot_w);
    return 2 * slot_w;
  endfunction

  function automatic int load_pos(int dly);
    return dly;
  endfunction

  function automatic int slot_pos(int bitc, int slot_w, int dly);
    int p;
    p = bitc - dly;
    if (p < 0) p = p + frame_bits(slot_w);
    return p;
  endfunction

endpackage

// File: rtl/i2s_bit_timer.sv
// Bit-clock divider and slot counter: bck, ws, frame-load strobe
// and the next bit position for the data select.
module i2s_bit_timer
  import i2s_pkg::*;
#(
  parameter int SLOT_W       = 16,
  parameter int BCK_DIV_LOG2 = 3,
  parameter int I2S_DELAY    = 0,
  localparam int BIT_W = $clog2(frame_bits(SLOT_W))
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             bck_o,
  output logic             ws_o,
  output logic             load_o,
  output logic [BIT_W-1:0] bit_nxt_o
);

  localparam int NBITS = frame_bits(SLOT_W);
  localparam logic [BIT_W-1:0] LAST = BIT_W'(NBITS - 1);
  localparam logic [BIT_W-1:0] LOAD = BIT_W'(load_pos(I2S_DELAY));
  localparam logic [BIT_W-1:0] WS_AT = BIT_W'(SLOT_W);

  logic [BCK_DIV_LOG2-1:0] div_q, div_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic                    run_q, run_d;
  logic                    ws_q, ws_d;
  logic                    wrap;

  // First enabled clk only arms the counters; it is also the
  // load point when the MSB sits on the ws edge.
  always_comb begin
    run_d = en;
    wrap  = en & run_q & (div_q == '1);
    div_d = '0;
    bit_d = '0;
    if (en & run_q) begin
      div_d = div_q + 1'b1;
      bit_d = bit_q;
      if (wrap) bit_d = (bit_q == LAST) ? '0 : bit_q + 1'b1;
    end
    ws_d   = (bit_d >= WS_AT);
    load_o = en & (run_q ? (wrap & (bit_d == LOAD))
                         : (LOAD == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      bit_q <= '0;
      run_q <= 1'b0;
      ws_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      bit_q <= bit_d;
      run_q <= run_d;
      ws_q  <= ws_d;
    end
  end

  assign bck_o     = div_q[BCK_DIV_LOG2-1];
  assign ws_o      = ws_q;
  assign bit_nxt_o = bit_d;

endmodule

// File: rtl/i2s_tx_stream.sv
// Stereo PCM to I2S / left-justified serial transmitter with a
// one-pair pending buffer ahead of the frame being shifted out.
module i2s_tx_stream
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W     = 16,
  parameter int SLOT_W       = 16,
  parameter int BCK_DIV_LOG2 = 3,
  parameter int I2S_DELAY    = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mute,
  input  logic [SAMPLE_W-1:0] in_left,
  input  logic [SAMPLE_W-1:0] in_right,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                underrun,
  output logic                audio_appsel,
  output logic                audio_sysclk,
  output logic                audio_bck,
  output logic                audio_ws,
  output logic                audio_data
);

  localparam int BIT_W = $clog2(frame_bits(SLOT_W));
  localparam int PAD   = MAX_W - SAMPLE_W;

  logic             load;
  logic [BIT_W-1:0] bit_nxt;

  stereo_t    in_pair;
  stereo_t    pend_q, pend_d;
  stereo_t    frame_q, frame_d;
  logic       pend_full_q, pend_full_d;
  logic       data_q, data_d;
  logic       under_q, under_d;
  logic       accept;
  logic       is_right;
  logic [MAX_W-1:0] word;
  int         pos;
  int         idx;

  i2s_bit_timer #(
    .SLOT_W       (SLOT_W),
    .BCK_DIV_LOG2 (BCK_DIV_LOG2),
    .I2S_DELAY    (I2S_DELAY)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .bck_o     (audio_bck),
    .ws_o      (audio_ws),
    .load_o    (load),
    .bit_nxt_o (bit_nxt)
  );

  always_comb begin
    in_pair.left  = MAX_W'(in_left) << PAD;
    in_pair.right = MAX_W'(in_right) << PAD;
    in_ready      = ~pend_full_q | load;
    accept        = in_valid & in_ready;
    pend_d        = accept ? in_pair : pend_q;
    pend_full_d   = accept | (pend_full_q & ~load);
    frame_d       = (load & pend_full_q) ? pend_q : frame_q;
    under_d       = load & ~pend_full_q;
    // Select from the frame and position that take effect this edge.
    pos      = slot_pos(int'(bit_nxt), SLOT_W, I2S_DELAY);
    is_right = (pos >= SLOT_W);
    idx      = is_right ? pos - SLOT_W : pos;
    word     = is_right ? frame_d.right : frame_d.left;
    data_d   = en & ~mute & word[5'(MAX_W - 1 - idx)];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      frame_q     <= '0;
      data_q      <= 1'b0;
      under_q     <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      frame_q     <= frame_d;
      data_q      <= data_d;
      under_q     <= under_d;
    end
  end

  assign underrun     = under_q;
  assign audio_data   = data_q;
  assign audio_appsel = 1'b1;
  assign audio_sysclk = clk;

endmodule
